// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit stepped processor datapath.
//   WORD_W        : bus / register word width in bits
//   word_t        : one bus word
//   IAR_RESET_VAL : value the instruction address register takes on reset
// -----------------------------------------------------------------------------
package cpu_pkg;
  localparam int unsigned WORD_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t IAR_RESET_VAL = 8'h00;
endpackage : cpu_pkg

// File: rtl/iar_reg_if.sv
// -----------------------------------------------------------------------------
// iar_reg_if
// Strobe and bus bundle between the control-step sequencer and the
// instruction address register.
//   s     : set strobe, load a_in on the next rising clk
//   e     : enable strobe, drive the stored value onto a_out
//   a_in  : bus value to be captured
//   a_out : bus drive from the register
// Modports:
//   master : sequencer side (drives s, e, a_in; observes a_out)
//   slave  : register side  (samples s, e, a_in; drives a_out)
// -----------------------------------------------------------------------------
interface iar_reg_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
);
  logic             s;
  logic             e;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] a_out;

  modport master (output s, output e, output a_in, input a_out);
  modport slave  (input s, input e, input a_in, output a_out);
endinterface : iar_reg_if

// File: rtl/byte_register.sv
// -----------------------------------------------------------------------------
// byte_register
// Clocked storage word with a level-sampled set strobe and a synchronous
// active-low reset. Reset wins over set.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-low reset, loads RESET_VAL
//   set_i  : load d_i on the next rising edge
//   d_i    : data to capture
//   q_o    : stored value
// -----------------------------------------------------------------------------
module byte_register
  import cpu_pkg::*;
#(
  parameter int unsigned          WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0]     RESET_VAL = IAR_RESET_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state: capture the bus word while set is high, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (set_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : byte_register

// File: rtl/iar_reg.sv
// -----------------------------------------------------------------------------
// iar_reg
// Instruction Address Register. Holds the address of the next instruction,
// loads it from the shared bus on the set strobe and drives it back onto the
// bus only while the enable strobe is high.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset (q <= RESET_VAL)
//   bus   : iar_reg_if.slave -- s, e, a_in in; a_out out
// Build option:
//   IAR_TRISTATE_EN defined   -> a_out is high-Z while e=0 (true tri-state bus)
//   IAR_TRISTATE_EN undefined -> a_out is all zeros while e=0 (wired-OR bus)
// The output path is combinational from q and e with no bypass from a_in, so
// a simultaneous set+enable shows the old value until the edge.
// -----------------------------------------------------------------------------
module iar_reg
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = IAR_RESET_VAL
) (
  input  logic     clk,
  input  logic     reset,
  iar_reg_if.slave bus
);

  logic [WIDTH-1:0] q_s;

  byte_register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .set_i (bus.s),
    .d_i   (bus.a_in),
    .q_o   (q_s)
  );

`ifdef IAR_TRISTATE_EN
  // Release the bus entirely while not enabled.
  assign bus.a_out = bus.e ? q_s : {WIDTH{1'bz}};
`else
  logic [WIDTH-1:0] a_out_s;

  // Zero is the idle value on the wired-OR bus.
  always_comb begin
    a_out_s = {WIDTH{1'b0}};
    if (bus.e) begin
      a_out_s = q_s;
    end else begin
      a_out_s = {WIDTH{1'b0}};
    end
  end

  assign bus.a_out = a_out_s;
`endif

endmodule : iar_reg

// File: tb/tb_iar_reg.sv
// -----------------------------------------------------------------------------
// tb_iar_reg
// Directed, table-driven bench for iar_reg. Each vector is applied after a
// falling edge; a_out is checked before the next rising edge (old q) and
// again shortly after it (new q).
// -----------------------------------------------------------------------------
module tb_iar_reg;
  import cpu_pkg::*;

  logic clk;
  logic reset;

  iar_reg_if #(.WIDTH(WORD_W)) bus ();

  iar_reg #(
    .WIDTH     (WORD_W),
    .RESET_VAL (IAR_RESET_VAL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  rst_n;
    logic  s;
    logic  e;
    word_t a_in;
    word_t exp_pre;   // a_out before the rising edge
    word_t exp_post;  // a_out after the rising edge
  } vec_t;

  int total;
  int bad;

  // Value expected on the bus when not enabled in this build.
  function automatic word_t idle_fix(input logic en, input word_t v);
`ifdef IAR_TRISTATE_EN
    if (!en) return {WORD_W{1'bz}};
`endif
    return v;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check around the rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset    = v.rst_n;
    bus.s    = v.s;
    bus.e    = v.e;
    bus.a_in = v.a_in;
    #1;
    check($sformatf("vec%0d_pre", idx), bus.a_out, idle_fix(v.e, v.exp_pre));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_post", idx), bus.a_out, idle_fix(v.e, v.exp_post));
  endtask

  vec_t vecs[$];

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    bus.s    = 1'b0;
    bus.e    = 1'b0;
    bus.a_in = 8'h00;

    //               rst_n  s     e     a_in   pre    post
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'hAA, 8'h00, 8'h00}); // reset, idle bus
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'hAA, 8'h00, 8'h00}); // reset value visible
    vecs.push_back('{1'b1, 1'b1, 8'b0, 8'hAA, 8'h00, 8'h00}); // load AA, e=0
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00}); // hold, not driven
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h33, 8'hAA, 8'hAA}); // e=1 same cycle
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 8'h00}); // e=0 again
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h77, 8'hAA, 8'h00}); // reset after load
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00}); // reset beats set
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h55, 8'h00, 8'h00}); // 55 discarded
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00}); // load 55
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 8'h55}); // 55 stored
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h11, 8'h55, 8'h11}); // load 11
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h22, 8'h11, 8'h22}); // s&e: old then new
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h33, 8'h22, 8'h33}); // held s reloads
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h44, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h5A, 8'h5A}); // last a_in wins
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hF0, 8'h5A, 8'h00}); // reset with e=1
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF}); // all ones
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h0F, 8'hFF, 8'hFF}); // hold FF

    foreach (vecs[i]) begin
      apply(vecs[i], i);
    end

    // Multi-cycle hold: s low, e high, bus noise must not disturb q.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset    = 1'b1;
      bus.s    = 1'b0;
      bus.e    = 1'b1;
      bus.a_in = 8'h10 + 8'(k);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d", k), bus.a_out, 8'hFF);
    end

    // Walking single-bit loads, read back one cycle later with e toggled.
    for (int b = 0; b < WORD_W; b++) begin
      @(negedge clk);
      bus.s    = 1'b1;
      bus.e    = 1'b0;
      bus.a_in = 8'h01 << b;
      @(negedge clk);
      bus.s    = 1'b0;
      #1;
      check($sformatf("walk%0d_idle", b), bus.a_out, idle_fix(1'b0, 8'h00));
      bus.e    = 1'b1;
      #1;
      check($sformatf("walk%0d_drv", b), bus.a_out, 8'h01 << b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_iar_reg
